// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution layer scheduler.
package conv_sched_pkg;
   localparam int NUM_KERNEL = 12;
   localparam int DIM_W      = 9;
   localparam int GRP_W      = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [DIM_W-1:0] width;
      logic [DIM_W-1:0] height;
      logic [GRP_W-1:0] num_kgrp;
   } cfg_t;

   function automatic logic cfg_ok(input cfg_t c);
      return (c.width != '0) && (c.height != '0) && (c.num_kgrp != '0);
   endfunction
endpackage

// File: rtl/conv_pix_scan.sv
// Row-major pixel coordinate counter: advances on i_en, wraps at width/height, decodes first/last.
// Zero latency on the decodes; counter holds whenever i_en is low, i_clr wins over i_en.
module conv_pix_scan
   import conv_sched_pkg::*;
(
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [DIM_W-1:0] i_width,
   input  logic [DIM_W-1:0] i_height,
   output logic [DIM_W-1:0] o_row,
   output logic [DIM_W-1:0] o_col,
   output logic             o_first,
   output logic             o_last
);
   logic [DIM_W-1:0] r_row;
   logic [DIM_W-1:0] r_col;
   logic             w_col_end;
   logic             w_row_end;

   assign w_col_end = (r_col == i_width - DIM_W'(1));
   assign w_row_end = (r_row == i_height - DIM_W'(1));

   // Wrapping the row on the last pixel leaves the counter at (0,0) for the next group.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_en) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + DIM_W'(1);
         end else begin
            r_col <= r_col + DIM_W'(1);
         end
      end
   end

   assign o_row   = r_row;
   assign o_col   = r_col;
   assign o_first = (r_row == '0) && (r_col == '0);
   assign o_last  = w_row_end && w_col_end;
endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler: per weight group, load weights, wait for a fresh ready, scan the map, drain the MACs.
// Control outputs are registered (1-cycle state latency); i_stall freezes the pixel scan in RUN.
module conv_layer_sched
   import conv_sched_pkg::*;
#(
   parameter int PIPE_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [DIM_W-1:0] i_cfg_width,
   input  logic [DIM_W-1:0] i_cfg_height,
   input  logic [GRP_W-1:0] i_cfg_num_kgrp,
   output logic             o_wload_en,
   input  logic             i_wready,
   output logic [GRP_W-1:0] o_kgrp,
   output logic             o_pix_valid,
   input  logic             i_stall,
   output logic [DIM_W-1:0] o_row,
   output logic [DIM_W-1:0] o_col,
   output logic             o_first_pix,
   output logic             o_last_pix,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);
   localparam int DRN_W = $clog2(PIPE_DEPTH + 1);
   localparam int TMO_W = $clog2(TIMEOUT);

   state_t           r_state;
   cfg_t             r_cfg;
   cfg_t             w_cfg_in;
   logic [GRP_W-1:0] r_kgrp;
   logic             r_wload_en;
   logic             r_busy;
   logic             r_pix_valid;
   logic             r_done;
   logic             r_err;
   logic             r_seen_low;
   logic [DRN_W-1:0] r_drain;
   logic [TMO_W-1:0] r_tmo;

   logic             w_accept;
   logic             w_wready_ok;
   logic             w_tmo_hit;
   logic             w_go_idle;
   logic             w_scan_clr;
   logic             w_first;
   logic             w_last;

   assign w_cfg_in    = '{width: i_cfg_width, height: i_cfg_height, num_kgrp: i_cfg_num_kgrp};
   assign w_accept    = r_pix_valid & ~i_stall;
   // A ready level held over from the previous group only counts after a low has been seen.
   assign w_wready_ok = i_wready & r_seen_low;
   assign w_tmo_hit   = (r_state == ST_WAIT) && !w_wready_ok && (r_tmo == TMO_W'(TIMEOUT - 1));
   assign w_go_idle   = rst | i_abort | w_tmo_hit | (r_state == ST_DONE);
   assign w_scan_clr  = rst | i_abort | (r_state != ST_RUN);

   conv_pix_scan u_scan (
      .clk      (clk),
      .i_clr    (w_scan_clr),
      .i_en     (w_accept),
      .i_width  (r_cfg.width),
      .i_height (r_cfg.height),
      .o_row    (o_row),
      .o_col    (o_col),
      .o_first  (w_first),
      .o_last   (w_last)
   );

   always_ff @(posedge clk) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_go_idle) begin
         r_state     <= ST_IDLE;
         r_cfg       <= '0;
         r_kgrp      <= '0;
         r_wload_en  <= 1'b0;
         r_busy      <= 1'b0;
         r_pix_valid <= 1'b0;
         r_seen_low  <= 1'b0;
         r_drain     <= '0;
         r_tmo       <= '0;
         r_err       <= !rst && !i_abort && w_tmo_hit;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  if (cfg_ok(w_cfg_in)) begin
                     r_cfg      <= w_cfg_in;
                     r_kgrp     <= '0;
                     r_wload_en <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= ST_LOAD;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               r_wload_en <= 1'b0;
               r_seen_low <= 1'b0;
               r_tmo      <= '0;
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_wready_ok) begin
                  r_pix_valid <= 1'b1;
                  r_state     <= ST_RUN;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
                  if (!i_wready) r_seen_low <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_accept && w_last) begin
                  r_pix_valid <= 1'b0;
                  r_drain     <= '0;
                  r_state     <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (r_drain == DRN_W'(PIPE_DEPTH - 1)) begin
                  if (r_kgrp == r_cfg.num_kgrp - GRP_W'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_kgrp     <= r_kgrp + GRP_W'(1);
                     r_wload_en <= 1'b1;
                     r_state    <= ST_LOAD;
                  end
               end else begin
                  r_drain <= r_drain + DRN_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_wload_en  = r_wload_en;
   assign o_kgrp      = r_kgrp;
   assign o_pix_valid = r_pix_valid;
   assign o_first_pix = r_pix_valid & w_first;
   assign o_last_pix  = r_pix_valid & w_last;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: scenario tasks against a loop-based model of the expected beat stream.
module tb_conv_layer_sched;
   localparam int PIPE = 4;
   localparam int TMO  = 1024;

   logic       clk = 1'b0;
   logic       rst, i_start, i_abort, i_wready, i_stall;
   logic [8:0] i_cfg_width, i_cfg_height;
   logic [5:0] i_cfg_num_kgrp;
   logic       o_wload_en, o_pix_valid, o_first_pix, o_last_pix, o_busy, o_done, o_err;
   logic [5:0] o_kgrp;
   logic [8:0] o_row, o_col;

   conv_layer_sched dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
      .i_cfg_width(i_cfg_width), .i_cfg_height(i_cfg_height), .i_cfg_num_kgrp(i_cfg_num_kgrp),
      .o_wload_en(o_wload_en), .i_wready(i_wready), .o_kgrp(o_kgrp), .o_pix_valid(o_pix_valid),
      .i_stall(i_stall), .o_row(o_row), .o_col(o_col), .o_first_pix(o_first_pix),
      .o_last_pix(o_last_pix), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   typedef struct packed { int k; int r; int c; bit f; bit l; } beat_t;

   beat_t beats[$];
   beat_t exp_q[$];
   int    beat_cyc[$], wl_cyc[$], wl_kgrp[$], done_cyc[$], err_cyc[$];
   int    cyc, start_cyc, busy_cnt, hold_bad, stall_hits;
   bit    timed_out;
   int    n_pass, n_total;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference stream: every group walks the whole map row-major.
   function automatic void build_expected(input int w, input int h, input int k);
      exp_q.delete();
      for (int g = 0; g < k; g++)
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
               exp_q.push_back('{k: g, r: r, c: c, f: (r == 0 && c == 0), l: (r == h-1 && c == w-1)});
   endfunction

   function automatic int beat_diffs();
      int d = 0;
      int n = (beats.size() > exp_q.size()) ? beats.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (i >= beats.size() || i >= exp_q.size() || beats[i] !== exp_q[i]) d++;
      return d;
   endfunction

   // Drives one layer: weight_ctrl model drops ready 1 cycle after load and raises it 3 cycles later.
   // stall_mode: 0 none, 1 hold 3 cycles at (1,3), 2 random. Abort fires at (ab_r,ab_c) of group 0.
   task automatic run_layer(input int w, input int h, input int k, input int stall_mode,
                            input int ab_r, input int ab_c, input bit stuck, input int budget);
      int wl_cnt = 100, st_cnt = 0, end_at = -1, prev_r = 0, prev_c = 0;
      bit prev_hold = 0, stall;
      beats.delete(); beat_cyc.delete(); wl_cyc.delete(); wl_kgrp.delete();
      done_cyc.delete(); err_cyc.delete();
      busy_cnt = 0; hold_bad = 0; stall_hits = 0; timed_out = 1;
      i_wready = 1'b1; i_stall = 1'b0;
      i_cfg_width = 9'(w); i_cfg_height = 9'(h); i_cfg_num_kgrp = 6'(k);
      i_start = 1'b1; start_cyc = cyc;
      tick();
      i_start = 1'b0;
      i_cfg_width = 9'($urandom); i_cfg_height = 9'($urandom); i_cfg_num_kgrp = 6'($urandom);
      for (int n = 0; n < budget; n++) begin
         if (end_at >= 0 && cyc >= end_at) begin timed_out = 0; break; end
         if (o_busy) busy_cnt++;
         if (o_wload_en) begin wl_cyc.push_back(cyc); wl_kgrp.push_back(int'(o_kgrp)); wl_cnt = 0; end
         else wl_cnt++;
         if (o_done) begin done_cyc.push_back(cyc); if (end_at < 0) end_at = cyc + 8; end
         if (o_err)  begin err_cyc.push_back(cyc);  if (end_at < 0) end_at = cyc + 8; end
         if (prev_hold && (!o_pix_valid || int'(o_row) != prev_r || int'(o_col) != prev_c)) hold_bad++;
         if (ab_r >= 0 && o_pix_valid && o_kgrp == 0 && int'(o_row) == ab_r && int'(o_col) == ab_c) begin
            i_abort = 1'b1;
            tick();
            i_abort = 1'b0; i_stall = 1'b0;
            timed_out = 0;
            return;
         end
         stall = 1'b0;
         if (stall_mode == 1) begin
            if (o_pix_valid && o_row == 1 && o_col == 3) begin
               if (st_cnt < 3) begin stall = 1'b1; st_cnt++; end
            end else st_cnt = 0;
         end else if (stall_mode == 2) begin
            stall = ($urandom_range(0, 2) == 0);
            i_start = o_busy && end_at < 0 && ($urandom_range(0, 7) == 0);
         end
         if (stall && o_pix_valid) stall_hits++;
         prev_hold = o_pix_valid && stall;
         prev_r = int'(o_row); prev_c = int'(o_col);
         i_wready = stuck ? 1'b1 : !(wl_cnt >= 1 && wl_cnt <= 3);
         i_stall  = stall;
         if (o_pix_valid && !stall) begin
            beats.push_back('{k: int'(o_kgrp), r: int'(o_row), c: int'(o_col), f: o_first_pix, l: o_last_pix});
            beat_cyc.push_back(cyc);
         end
         tick();
      end
      i_start = 1'b0; i_stall = 1'b0; i_wready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_abort = 1'b1; i_start = 1'b1;
      i_cfg_width = 9'd4; i_cfg_height = 9'd3; i_cfg_num_kgrp = 6'd2;
      tick(); tick();
      n_total++;
      if ({o_wload_en, o_pix_valid, o_first_pix, o_last_pix, o_busy, o_done, o_err} !== 7'b0)
         $display("FAIL reset_flags: got %b, expected 0", {o_wload_en, o_pix_valid, o_first_pix, o_last_pix, o_busy, o_done, o_err});
      else n_pass++;
      n_total++;
      if ({o_kgrp, o_row, o_col} !== 24'b0)
         $display("FAIL reset_counters: got kgrp=%0d row=%0d col=%0d, expected 0", o_kgrp, o_row, o_col);
      else n_pass++;
      rst = 1'b0; i_abort = 1'b0; i_start = 1'b0;
      tick(); tick();
      n_total++;
      if ({o_wload_en, o_pix_valid, o_busy, o_done, o_err, o_kgrp, o_row, o_col} !== 29'b0)
         $display("FAIL idle_after_reset: got busy=%b wload=%b err=%b, expected all 0", o_busy, o_wload_en, o_err);
      else n_pass++;
   endtask

   task automatic test_basic();
      int gap_bad = 0, lat_bad = 0, kg_bad = 0;
      build_expected(4, 3, 2);
      run_layer(4, 3, 2, 0, -1, -1, 0, 300);
      n_total++;
      if (timed_out !== 0) $display("FAIL basic_timeout: got %0d, expected 0", timed_out); else n_pass++;
      n_total++;
      if (beat_diffs() !== 0) $display("FAIL basic_beats: got %0d bad of %0d, expected 0", beat_diffs(), beats.size());
      else n_pass++;
      n_total++;
      if (wl_cyc.size() !== 2) $display("FAIL basic_wload_count: got %0d, expected 2", wl_cyc.size()); else n_pass++;
      n_total++;
      if (done_cyc.size() !== 1 || err_cyc.size() !== 0)
         $display("FAIL basic_done_err: got done=%0d err=%0d, expected 1 and 0", done_cyc.size(), err_cyc.size());
      else n_pass++;
      if (wl_cyc.size() == 2 && done_cyc.size() == 1 && beats.size() == 24) begin
         for (int g = 0; g < 2; g++) begin
            if (wl_kgrp[g] != g) kg_bad++;
            if (beat_cyc[g*12] - wl_cyc[g] != 5) lat_bad++;
            if (((g == 1) ? done_cyc[0] : wl_cyc[g+1]) - beat_cyc[g*12+11] != PIPE + 1) gap_bad++;
         end
         n_total++;
         if (kg_bad !== 0) $display("FAIL basic_wload_kgrp: got %0d bad, expected 0", kg_bad); else n_pass++;
         n_total++;
         if (lat_bad !== 0) $display("FAIL basic_load_to_run: got %0d bad, expected 0", lat_bad); else n_pass++;
         n_total++;
         if (gap_bad !== 0) $display("FAIL basic_drain_gap: got %0d bad, expected 0", gap_bad); else n_pass++;
         n_total++;
         if (busy_cnt !== done_cyc[0] - wl_cyc[0] + 1)
            $display("FAIL basic_busy: got %0d, expected %0d", busy_cnt, done_cyc[0] - wl_cyc[0] + 1);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      build_expected(4, 3, 2);
      run_layer(4, 3, 2, 1, -1, -1, 0, 300);
      n_total++;
      if (beat_diffs() !== 0 || timed_out !== 0)
         $display("FAIL stall_beats: got %0d bad (timeout=%0d), expected 0", beat_diffs(), timed_out);
      else n_pass++;
      n_total++;
      if (stall_hits !== 6) $display("FAIL stall_hits: got %0d, expected 6", stall_hits); else n_pass++;
      n_total++;
      if (hold_bad !== 0) $display("FAIL stall_hold: got %0d moves, expected 0", hold_bad); else n_pass++;
      n_total++;
      if (done_cyc.size() !== 1) $display("FAIL stall_done: got %0d, expected 1", done_cyc.size()); else n_pass++;
   endtask

   task automatic test_bad_cfg();
      int cw[3] = '{0, 4, 4};
      int ch[3] = '{3, 0, 3};
      int ck[3] = '{2, 2, 0};
      for (int i = 0; i < 3; i++) begin
         run_layer(cw[i], ch[i], ck[i], 0, -1, -1, 0, 20);
         n_total++;
         if (err_cyc.size() !== 1 || err_cyc[0] - start_cyc !== 1)
            $display("FAIL badcfg_err_%0d: got %0d pulses, expected 1 pulse one cycle after start", i, err_cyc.size());
         else n_pass++;
         n_total++;
         if (busy_cnt !== 0 || wl_cyc.size() !== 0)
            $display("FAIL badcfg_quiet_%0d: got busy=%0d wload=%0d, expected 0", i, busy_cnt, wl_cyc.size());
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      run_layer(4, 3, 1, 0, -1, -1, 1, 1200);
      n_total++;
      if (err_cyc.size() !== 1 || wl_cyc.size() !== 1 || err_cyc[0] - wl_cyc[0] !== TMO + 1)
         $display("FAIL timeout_err: got %0d err pulses, expected one %0d cycles after load", err_cyc.size(), TMO + 1);
      else n_pass++;
      n_total++;
      if (done_cyc.size() !== 0 || beats.size() !== 0)
         $display("FAIL timeout_no_done: got done=%0d beats=%0d, expected 0", done_cyc.size(), beats.size());
      else n_pass++;
      n_total++;
      if (busy_cnt !== TMO + 1) $display("FAIL timeout_busy: got %0d, expected %0d", busy_cnt, TMO + 1); else n_pass++;
   endtask

   task automatic test_abort();
      run_layer(4, 3, 2, 0, 2, 1, 0, 200);
      n_total++;
      if ({o_wload_en, o_pix_valid, o_first_pix, o_last_pix, o_busy, o_done, o_err, o_kgrp, o_row, o_col} !== 31'b0)
         $display("FAIL abort_outputs: got busy=%b valid=%b row=%0d col=%0d, expected all 0", o_busy, o_pix_valid, o_row, o_col);
      else n_pass++;
      n_total++;
      if (beats.size() !== 9) $display("FAIL abort_beats: got %0d, expected 9", beats.size()); else n_pass++;
      tick(); tick();
      n_total++;
      if ({o_busy, o_done, o_err} !== 3'b0) $display("FAIL abort_quiet: got %b, expected 000", {o_busy, o_done, o_err});
      else n_pass++;
      build_expected(4, 3, 2);
      run_layer(4, 3, 2, 0, -1, -1, 0, 300);
      n_total++;
      if (beat_diffs() !== 0 || done_cyc.size() !== 1)
         $display("FAIL abort_rerun: got %0d bad beats, %0d done, expected 0 and 1", beat_diffs(), done_cyc.size());
      else n_pass++;
   endtask

   task automatic test_1x1();
      build_expected(1, 1, 1);
      run_layer(1, 1, 1, 0, -1, -1, 0, 100);
      n_total++;
      if (beat_diffs() !== 0) $display("FAIL one_pix_beats: got %0d bad of %0d, expected 0", beat_diffs(), beats.size());
      else n_pass++;
      n_total++;
      if (done_cyc.size() !== 1 || beats.size() !== 1 || done_cyc[0] - beat_cyc[0] !== PIPE + 1)
         $display("FAIL one_pix_drain: got %0d done, expected one %0d cycles after the beat", done_cyc.size(), PIPE + 1);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         int w = $urandom_range(1, 6);
         int h = $urandom_range(1, 5);
         int k = $urandom_range(1, 3);
         build_expected(w, h, k);
         run_layer(w, h, k, 2, -1, -1, 0, 2000);
         n_total++;
         if (beat_diffs() !== 0 || timed_out !== 0)
            $display("FAIL rand_beats_%0dx%0dx%0d: got %0d bad (timeout=%0d), expected 0", w, h, k, beat_diffs(), timed_out);
         else n_pass++;
         n_total++;
         if (wl_cyc.size() !== k || done_cyc.size() !== 1 || err_cyc.size() !== 0)
            $display("FAIL rand_events_%0d: got wload=%0d done=%0d err=%0d, expected %0d/1/0", it, wl_cyc.size(), done_cyc.size(), err_cyc.size(), k);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0; cyc = 0;
      rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_wready = 1'b1; i_stall = 1'b0;
      i_cfg_width = '0; i_cfg_height = '0; i_cfg_num_kgrp = '0;
      test_reset();
      test_basic();
      test_stall();
      test_bad_cfg();
      test_timeout();
      test_abort();
      test_1x1();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
